mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx_pkg.sv | 25 ++
 rtl/mmio_uart_tx_if.sv | 27 ++
 rtl/mmio_uart_tx_fifo.sv | 55 +++++
 rtl/mmio_uart_tx.sv | 146 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// FSM encodings, register offsets and the STATUS word layout.
package mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  function automatic logic [31:0] status_word(
    input logic       full,
    input logic       empty,
    input logic       busy,
    input logic       ovf,
    input logic [4:0] cnt
  );
    return {23'd0, cnt, ovf, busy, empty, full};
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor data-memory bus as seen by an MMIO peripheral.
// The CPU side is the master; the peripheral decodes and answers.
interface mmio_uart_tx_if;

  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic        sel;
  logic [31:0] rdata;

  modport master (
    output memwrite,
    output dataaddr,
    output writedata,
    input  sel,
    input  rdata
  );

  modport slave (
    input  memwrite,
    input  dataaddr,
    input  writedata,
    output sel,
    output rdata
  );

endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; push ignored when full,
// pop ignored when empty, head visible combinationally on dout.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO 8N1 UART transmitter: TXDATA/STATUS registers on the
// data-memory bus, a byte FIFO and a bit-timing FSM.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memwrite,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0] A_TX   = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0] A_ST   = BASE_ADDR + STATUS_OFS;

  state_t      r_state, w_nstate;
  logic [15:0] r_cnt, w_ncnt;
  logic [2:0]  r_idx, w_nidx;
  logic [7:0]  r_sh, w_nsh;
  logic        r_tx, w_ntx;
  logic        r_ovf;

  logic          w_hit_tx, w_hit_st;
  logic          w_wr_tx, w_clr;
  logic          w_pop;
  logic [7:0]    w_head;
  logic          w_full, w_empty;
  logic [CW-1:0] w_count;
  logic          w_unused;

  assign w_hit_tx = (dataaddr == A_TX);
  assign w_hit_st = (dataaddr == A_ST);
  assign w_wr_tx  = memwrite & w_hit_tx;
  assign w_clr    = memwrite & w_hit_st & writedata[3];
  assign w_unused = ^writedata[31:8];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (w_wr_tx),
    .pop    (w_pop),
    .din    (writedata[7:0]),
    .dout   (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  // A write landing on a full FIFO is lost even if a pop frees a slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_ovf <= 1'b0;
    else if (w_wr_tx & w_full) r_ovf <= 1'b1;
    else if (w_clr)            r_ovf <= 1'b0;
  end

  assign sel   = w_hit_tx | w_hit_st;
  assign busy  = (r_state != IDLE);
  assign tx    = r_tx;
  assign rdata = w_hit_st
    ? status_word(w_full, w_empty, busy, r_ovf, 5'(w_count))
    : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_idx   <= w_nidx;
      r_sh    <= w_nsh;
      r_tx    <= w_ntx;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nidx   = r_idx;
    w_nsh    = r_sh;
    w_ntx    = r_tx;
    w_pop    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop    = 1'b1;
          w_nsh    = w_head;
          w_ncnt   = RELOAD;
          w_ntx    = 1'b0;
          w_nstate = START;
        end
      end
      START: begin
        if (r_cnt == '0) begin
          w_nstate = DATA;
          w_ncnt   = RELOAD;
          w_nidx   = '0;
          w_ntx    = r_sh[0];
        end else begin
          w_ncnt = r_cnt - 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == '0) begin
          w_ncnt = RELOAD;
          if (r_idx == 3'd7) begin
            w_nstate = STOP;
            w_ntx    = 1'b1;
          end else begin
            w_nidx = r_idx + 1'b1;
            w_nsh  = {1'b0, r_sh[7:1]};
            w_ntx  = r_sh[1];
          end
        end else begin
          w_ncnt = r_cnt - 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == '0) begin
          w_nstate = IDLE;
          w_nidx   = '0;
        end else begin
          w_ncnt = r_cnt - 1'b1;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register decode table, frame
// timing, FIFO overflow, back-to-back frames and mid-frame reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] STA  = BASE + 32'd4;
  localparam logic [31:0] PARK = 32'h0000_0100;
  localparam int          CPB  = 4;

  logic clk;
  logic reset_n;
  logic tx;
  logic busy;
  int   total;
  int   bad;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .memwrite (bus.memwrite),
    .dataaddr (bus.dataaddr),
    .writedata(bus.writedata),
    .sel      (bus.sel),
    .rdata    (bus.rdata),
    .tx       (tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.dataaddr  = a;
    bus.writedata = d;
    step();
    bus.memwrite = 1'b0;
    bus.dataaddr = PARK;
  endtask

  task automatic rd_status(output logic [31:0] v);
    bus.memwrite = 1'b0;
    bus.dataaddr = STA;
    #1;
    v = bus.rdata;
    bus.dataaddr = PARK;
  endtask

  task automatic wait_idle();
    int n;
    logic [31:0] s;
    n = 0;
    rd_status(s);
    while ((busy !== 1'b0 || s[1] !== 1'b1) && n < 2000) begin
      step();
      rd_status(s);
      n++;
    end
    chk("wait_idle_timeout", 32'(n >= 2000), 32'd0);
  endtask

  task automatic rx_byte(output logic [7:0] b);
    int n;
    b = 8'h00;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk("rx_gap_timeout", 32'(n >= 200), 32'd0);
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk("rx_start_timeout", 32'(n >= 200), 32'd0);
    repeat (2) step();
    chk("rx_start_mid", 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) step();
      b[i] = tx;
    end
    repeat (CPB) step();
    chk("rx_stop_mid", 32'(tx), 32'd1);
  endtask

  initial begin
    logic [31:0] s;
    logic [7:0]  rb;
    logic [9:0]  frame;
    logic        low_seen;

    total = 0;
    bad   = 0;

    vecs[0] = '{1'b0, BASE,          32'h0,  1'b1, 32'h0};
    vecs[1] = '{1'b0, STA,           32'h0,  1'b1, 32'h2};
    vecs[2] = '{1'b0, BASE + 32'd8,  32'h0,  1'b0, 32'h0};
    vecs[3] = '{1'b0, BASE - 32'd4,  32'h0,  1'b0, 32'h0};
    vecs[4] = '{1'b1, BASE + 32'd8,  32'h55, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h0,         32'h55, 1'b0, 32'h0};
    vecs[6] = '{1'b1, STA,           32'h8,  1'b1, 32'h2};

    reset_n       = 1'b0;
    bus.memwrite  = 1'b0;
    bus.dataaddr  = PARK;
    bus.writedata = 32'h0;
    repeat (3) step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rd_status(s);
    chk("rst_status", s, 32'h2);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Decode table; writes outside the register pair must be ignored.
    for (int i = 0; i < 7; i++) begin
      bus.memwrite  = vecs[i].we;
      bus.dataaddr  = vecs[i].addr;
      bus.writedata = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rd);
      step();
      bus.memwrite = 1'b0;
      bus.dataaddr = PARK;
    end
    rd_status(s);
    chk("stray_wr_status", s, 32'h2);
    chk("stray_wr_tx", 32'(tx), 32'd1);

    // Single frame 0xA5.
    wr(BASE, 32'h0000_00A5);
    chk("a5_tx_write_edge", 32'(tx), 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      step();
      chk($sformatf("a5_tx_c%0d", c), 32'(tx), 32'(frame[c / CPB]));
      chk($sformatf("a5_busy_c%0d", c), 32'(busy), 32'd1);
    end
    step();
    chk("a5_end_busy", 32'(busy), 32'd0);
    chk("a5_end_tx", 32'(tx), 32'd1);

    // Fill the FIFO while the first byte is in flight, then overflow.
    wait_idle();
    for (int i = 0; i < 5; i++) wr(BASE, 32'h11 + 32'(i));
    rd_status(s);
    chk("fill_status", s, 32'h45);
    for (int i = 0; i < 4; i++) wr(BASE, 32'h20 + 32'(i));
    rd_status(s);
    chk("ovf_status_nobusy", s & ~32'h4, 32'h49);
    chk("ovf_busy", 32'(busy), 32'd1);
    wr(STA, 32'h0000_0008);
    rd_status(s);
    chk("ovf_clear_status", s, 32'h45);
    for (int i = 0; i < 4; i++) begin
      rx_byte(rb);
      chk($sformatf("drain_byte%0d", i), 32'(rb), 32'h12 + 32'(i));
    end
    wait_idle();
    rd_status(s);
    chk("drain_status", s, 32'h2);

    // Back-to-back frames 0x01 then 0x80; the second start is 41 later.
    wr(BASE, 32'h01);
    wr(BASE, 32'h80);
    chk("b2b_f1_start", 32'(tx), 32'd0);
    for (int c = 1; c <= 76; c++) begin
      step();
      case (c)
        6:  chk("b2b_f1_bit0", 32'(tx), 32'd1);
        34: chk("b2b_f1_bit7", 32'(tx), 32'd0);
        39: chk("b2b_f1_stop", 32'({tx, busy}), 32'b11);
        40: chk("b2b_gap", 32'({tx, busy}), 32'b10);
        41: chk("b2b_f2_start", 32'({tx, busy}), 32'b01);
        47: chk("b2b_f2_bit0", 32'(tx), 32'd0);
        75: chk("b2b_f2_bit7", 32'(tx), 32'd1);
        default: ;
      endcase
    end

    // Reset in the middle of the data bits, with a byte still queued.
    wait_idle();
    wr(BASE, 32'h00);
    wr(BASE, 32'h33);
    repeat (8) step();
    chk("pre_rst_state", 32'({tx, busy}), 32'b01);
    reset_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    #2;
    reset_n = 1'b1;
    step();
    rd_status(s);
    chk("post_rst_status", s, 32'h2);
    low_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    chk("post_rst_tx_quiet", 32'(low_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
